// File: rtl/coeff_update_ctrl_pkg.sv
// Shared FIR definitions: sequencer state encoding, default geometry and the
// idle levels of the SRAM/MAC control outputs (also used by the module selector).
package coeff_update_ctrl_pkg;

    localparam int NUM_BANK      = 4;
    localparam int TAPS_PER_BANK = 10;
    localparam int ADDR_W        = 4;
    localparam int DATA_W        = 16;
    localparam int TOTAL_TAPS    = NUM_BANK * TAPS_PER_BANK;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RUN_WAIT = 2'd2,
        ST_SWEEP    = 2'd3
    } state_e;

    // Idle levels of the control outputs (no SRAM access, no MAC activity)
    localparam logic CSN_IDLE         = 1'b1;
    localparam logic WRN_IDLE         = 1'b1;
    localparam logic EN_MAC_IDLE      = 1'b0;
    localparam logic SWEEP_DONE_IDLE  = 1'b0;
    localparam logic OVERRUN_IDLE     = 1'b0;
    localparam logic COEFF_READY_IDLE = 1'b0;

    // Bank-select width; a single bank still needs a 1-bit select
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SEL_W = sel_width(NUM_BANK);

endpackage

// File: rtl/coeff_update_ctrl_if.sv
// Coefficient-load handshake, sample strobe and SRAM/MAC control bundle.
// master: the sequencer; slave: the side feeding coefficients / consuming SRAM control.
interface coeff_update_ctrl_if #(
    parameter int ADDR_W = coeff_update_ctrl_pkg::ADDR_W,
    parameter int DATA_W = coeff_update_ctrl_pkg::DATA_W,
    parameter int SEL_W  = coeff_update_ctrl_pkg::SEL_W
);

    logic              iCoeffUpdateFlag;
    logic              iCoeffValid;
    logic [DATA_W-1:0] iCoeffData;
    logic              oCoeffReady;
    logic              iEnSample;
    logic [SEL_W-1:0]  oModuleSel;
    logic              oCsnRam;
    logic              oWrnRam;
    logic [ADDR_W-1:0] oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;
    logic              oEnMAC;
    logic              oSweepDone;
    logic              oOverrun;

    modport master (
        input  iCoeffUpdateFlag, iCoeffValid, iCoeffData, iEnSample,
        output oCoeffReady, oModuleSel, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oEnMAC, oSweepDone, oOverrun
    );

    modport slave (
        output iCoeffUpdateFlag, iCoeffValid, iCoeffData, iEnSample,
        input  oCoeffReady, oModuleSel, oCsnRam, oWrnRam, oAddrRam,
               oWtDtRam, oEnMAC, oSweepDone, oOverrun
    );

endinterface

// File: rtl/coeff_update_ctrl_tap_bank_counter.sv
// Tap/bank position counter shared by the load and sweep phases. Tap wraps at
// TAPS_PER_BANK and carries into bank. Exposes both the current and the
// post-edge position so the caller can register an address one step ahead.
module tap_bank_counter #(
    parameter int NUM_BANK      = coeff_update_ctrl_pkg::NUM_BANK,
    parameter int TAPS_PER_BANK = coeff_update_ctrl_pkg::TAPS_PER_BANK,
    parameter int BANK_W        = coeff_update_ctrl_pkg::SEL_W,
    parameter int TAP_W         = coeff_update_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BANK_W-1:0] bank_o,
    output logic [TAP_W-1:0]  tap_o,
    output logic [BANK_W-1:0] bank_nxt_o,
    output logic [TAP_W-1:0]  tap_nxt_o,
    output logic              last_o
);

    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS_PER_BANK - 1);

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [TAP_W-1:0]  tap_q,  tap_d;

    // Next position: clear wins over increment; tap carries into bank
    always_comb begin
        bank_d = bank_q;
        tap_d  = tap_q;
        if (clr_i) begin
            bank_d = '0;
            tap_d  = '0;
        end else if (inc_i) begin
            if (tap_q == TAP_LAST) begin
                tap_d  = '0;
                bank_d = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
            end else begin
                tap_d = tap_q + 1'b1;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
            tap_q  <= '0;
        end else begin
            bank_q <= bank_d;
            tap_q  <= tap_d;
        end
    end

    assign bank_o     = bank_q;
    assign tap_o      = tap_q;
    assign bank_nxt_o = bank_d;
    assign tap_nxt_o  = tap_d;
    assign last_o     = (bank_q == BANK_LAST) && (tap_q == TAP_LAST);

endmodule

// File: rtl/coeff_update_ctrl.sv
// Coefficient load / sweep sequencer in front of the FIR module selector.
// LOAD writes one incoming coefficient per accepted word into bank/tap order;
// SWEEP issues one read + MAC enable per tap after each sample strobe.
// Every SRAM/MAC output comes straight from a flop.
module coeff_update_ctrl #(
    parameter int NUM_BANK      = coeff_update_ctrl_pkg::NUM_BANK,
    parameter int TAPS_PER_BANK = coeff_update_ctrl_pkg::TAPS_PER_BANK,
    parameter int ADDR_W        = coeff_update_ctrl_pkg::ADDR_W,
    parameter int DATA_W        = coeff_update_ctrl_pkg::DATA_W
) (
    input  logic                iClk12M,
    input  logic                iRsn,
    coeff_update_ctrl_if.master bus
);

    import coeff_update_ctrl_pkg::*;

    localparam int SEL_W = sel_width(NUM_BANK);

    state_e            state_q, state_d;

    logic [SEL_W-1:0]  sel_q,      sel_d;
    logic              csn_q,      csn_d;
    logic              wrn_q,      wrn_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              en_mac_q,   en_mac_d;
    logic              done_q,     done_d;
    logic              overrun_q,  overrun_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [SEL_W-1:0]  cnt_bank;
    logic [ADDR_W-1:0] cnt_tap;
    logic [SEL_W-1:0]  cnt_bank_nxt;
    logic [ADDR_W-1:0] cnt_tap_nxt;
    logic              cnt_last;

    tap_bank_counter #(
        .NUM_BANK      (NUM_BANK),
        .TAPS_PER_BANK (TAPS_PER_BANK),
        .BANK_W        (SEL_W),
        .TAP_W         (ADDR_W)
    ) u_tap_bank_counter (
        .clk        (iClk12M),
        .rst_n      (iRsn),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .bank_o     (cnt_bank),
        .tap_o      (cnt_tap),
        .bank_nxt_o (cnt_bank_nxt),
        .tap_nxt_o  (cnt_tap_nxt),
        .last_o     (cnt_last)
    );

    // Sequencer state register
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and next values of the registered outputs.
    // LOAD writes at the counter's current position, then advances it.
    // SWEEP registers the position the counter holds after this edge, so the
    // read for tap k is on the outputs while the counter holds k.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        sel_d     = '0;
        csn_d     = CSN_IDLE;
        wrn_d     = WRN_IDLE;
        addr_d    = '0;
        wdata_d   = '0;
        en_mac_d  = EN_MAC_IDLE;
        done_d    = SWEEP_DONE_IDLE;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                // sample strobes are meaningless without coefficients
                if (bus.iCoeffUpdateFlag) begin
                    state_d   = ST_LOAD;
                    cnt_clr   = 1'b1;
                    overrun_d = OVERRUN_IDLE;
                end
            end

            ST_LOAD: begin
                // a dropped flag aborts even if a word is offered that cycle
                if (!bus.iCoeffUpdateFlag) begin
                    state_d = ST_IDLE;
                end else if (bus.iCoeffValid) begin
                    cnt_inc = 1'b1;
                    sel_d   = cnt_bank;
                    addr_d  = cnt_tap;
                    wdata_d = bus.iCoeffData;
                    csn_d   = 1'b0;
                    wrn_d   = 1'b0;
                    if (cnt_last) begin
                        state_d = ST_RUN_WAIT;
                    end
                end
            end

            ST_RUN_WAIT: begin
                // reload wins; a same-cycle strobe is dropped silently
                if (bus.iCoeffUpdateFlag) begin
                    state_d   = ST_LOAD;
                    cnt_clr   = 1'b1;
                    overrun_d = OVERRUN_IDLE;
                end else if (bus.iEnSample) begin
                    state_d  = ST_SWEEP;
                    cnt_clr  = 1'b1;
                    sel_d    = cnt_bank_nxt;
                    addr_d   = cnt_tap_nxt;
                    csn_d    = 1'b0;
                    wrn_d    = 1'b1;
                    en_mac_d = 1'b1;
                end
            end

            ST_SWEEP: begin
                // a strobe here is lost; the running sweep is not restarted
                if (bus.iEnSample) begin
                    overrun_d = 1'b1;
                end
                if (cnt_last) begin
                    state_d = ST_RUN_WAIT;
                    done_d  = 1'b1;
                end else begin
                    cnt_inc  = 1'b1;
                    sel_d    = cnt_bank_nxt;
                    addr_d   = cnt_tap_nxt;
                    csn_d    = 1'b0;
                    wrn_d    = 1'b1;
                    en_mac_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM/MAC output registers; reset drops them to idle immediately
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            sel_q     <= '0;
            csn_q     <= CSN_IDLE;
            wrn_q     <= WRN_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            en_mac_q  <= EN_MAC_IDLE;
            done_q    <= SWEEP_DONE_IDLE;
            overrun_q <= OVERRUN_IDLE;
        end else begin
            sel_q     <= sel_d;
            csn_q     <= csn_d;
            wrn_q     <= wrn_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            en_mac_q  <= en_mac_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.oCoeffReady = (state_q == ST_LOAD);
    assign bus.oModuleSel  = sel_q;
    assign bus.oCsnRam     = csn_q;
    assign bus.oWrnRam     = wrn_q;
    assign bus.oAddrRam    = addr_q;
    assign bus.oWtDtRam    = wdata_q;
    assign bus.oEnMAC      = en_mac_q;
    assign bus.oSweepDone  = done_q;
    assign bus.oOverrun    = overrun_q;

endmodule

// File: tb/tb_coeff_update_ctrl.sv
// Directed bench for coeff_update_ctrl. Inputs change and outputs are sampled
// on the falling edge; expected output words are built from constants.
module tb_coeff_update_ctrl;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    coeff_update_ctrl_if bus ();

    coeff_update_ctrl dut (
        .iClk12M (clk),
        .iRsn    (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, overrun, done, en_mac, csn, wrn, sel[1:0], addr[3:0], data[15:0]}
    function automatic logic [27:0] pack(input logic rdy, input logic ovr,
                                         input logic done, input logic en,
                                         input logic csn, input logic wrn,
                                         input logic [1:0] sel, input logic [3:0] addr,
                                         input logic [15:0] data);
        return {rdy, ovr, done, en, csn, wrn, sel, addr, data};
    endfunction

    function automatic logic [27:0] obs();
        return pack(bus.oCoeffReady, bus.oOverrun, bus.oSweepDone, bus.oEnMAC,
                    bus.oCsnRam, bus.oWrnRam, bus.oModuleSel, bus.oAddrRam, bus.oWtDtRam);
    endfunction

    function automatic logic [27:0] idle_exp(input logic rdy, input logic ovr);
        return pack(rdy, ovr, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 16'h0000);
    endfunction

    function automatic logic [27:0] wr_exp(input int k, input logic [15:0] data, input logic rdy);
        return pack(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(k / 10), 4'(k % 10), data);
    endfunction

    function automatic logic [27:0] rd_exp(input int j, input logic ovr);
        return pack(1'b0, ovr, 1'b0, 1'b1, 1'b0, 1'b1, 2'(j / 10), 4'(j % 10), 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [27:0] act, input logic [27:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Full 40-word load with continuous valid; called on a falling edge in IDLE or RUN_WAIT
    task automatic load_all(input logic [15:0] base);
        bus.iCoeffUpdateFlag = 1'b1;
        @(negedge clk);
        chk("ld_entry", obs(), idle_exp(1'b1, 1'b0));
        bus.iCoeffValid = 1'b1;
        bus.iCoeffData  = base;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("ld_wr%0d", k), obs(), wr_exp(k, 16'(base + 16'(k)), (k != 39)));
            if (k == 39) begin
                bus.iCoeffValid      = 1'b0;
                bus.iCoeffUpdateFlag = 1'b0;
                bus.iCoeffData       = 16'h0000;
            end else begin
                bus.iCoeffData = 16'(base + 16'(k + 1));
            end
        end
        @(negedge clk);
        chk("ld_post", obs(), idle_exp(1'b0, 1'b0));
    endtask

    // One sweep from RUN_WAIT; with inject, a lost strobe at read 20 and a
    // deferred reload request during the sweep
    task automatic sweep(input bit inject);
        logic ovr;
        ovr = 1'b0;
        bus.iEnSample = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            bus.iEnSample = 1'b0;
            if (inject && j == 20) ovr = 1'b1;
            chk($sformatf("sw_rd%0d", j), obs(), rd_exp(j, ovr));
            if (inject && j == 19) bus.iEnSample = 1'b1;
            if (inject && j == 25) bus.iCoeffUpdateFlag = 1'b1;
        end
        @(negedge clk);
        chk("sw_done", obs(), pack(1'b0, ovr, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 16'h0000));
        @(negedge clk);
        if (inject) chk("sw_reload", obs(), idle_exp(1'b1, 1'b0));
        else        chk("sw_post", obs(), idle_exp(1'b0, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic v;
        n_tests = 0;
        n_fail  = 0;
        rst_n                = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        bus.iCoeffValid      = 1'b0;
        bus.iCoeffData       = 16'h0000;
        bus.iEnSample        = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("reset", obs(), idle_exp(1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rel", obs(), idle_exp(1'b0, 1'b0));

        // strobe in IDLE is ignored and is not an overrun
        bus.iEnSample = 1'b1;
        @(negedge clk);
        bus.iEnSample = 1'b0;
        chk("idle_strobe", obs(), idle_exp(1'b0, 1'b0));
        @(negedge clk);
        chk("idle_strobe2", obs(), idle_exp(1'b0, 1'b0));

        // full load then a clean sweep
        load_all(16'h0100);
        sweep(1'b0);

        // stalled load from RUN_WAIT: gaps on valid, then abort after 17 words
        bus.iCoeffUpdateFlag = 1'b1;
        @(negedge clk);
        chk("stl_entry", obs(), idle_exp(1'b1, 1'b0));
        acc = 0;
        for (int c = 0; c < 22; c++) begin
            v = (c == 1 || c == 3) ? 1'b0 : (acc < 17);
            bus.iCoeffValid = v;
            bus.iCoeffData  = 16'(16'h0200 + 16'(acc));
            @(negedge clk);
            if (v) begin
                chk($sformatf("stl_wr%0d", acc), obs(), wr_exp(acc, 16'(16'h0200 + 16'(acc)), 1'b1));
                acc++;
            end else begin
                chk($sformatf("stl_gap%0d", c), obs(), idle_exp(1'b1, 1'b0));
            end
        end
        bus.iCoeffValid      = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        @(negedge clk);
        chk("abort_idle", obs(), idle_exp(1'b0, 1'b0));
        bus.iCoeffValid = 1'b1;
        bus.iCoeffData  = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_nowr%0d", c), obs(), idle_exp(1'b0, 1'b0));
        end
        bus.iCoeffValid = 1'b0;
        bus.iCoeffData  = 16'h0000;

        // overrun during a sweep, deferred reload clears it
        load_all(16'h0400);
        sweep(1'b1);
        bus.iCoeffUpdateFlag = 1'b0;
        @(negedge clk);
        chk("reload_abort", obs(), idle_exp(1'b0, 1'b0));

        // asynchronous reset in the middle of a sweep at tap 5
        load_all(16'h0300);
        bus.iEnSample = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            bus.iEnSample = 1'b0;
            chk($sformatf("pre_rst_rd%0d", j), obs(), rd_exp(j, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1 chk("rst_async", obs(), idle_exp(1'b0, 1'b0));
        @(negedge clk);
        chk("rst_held", obs(), idle_exp(1'b0, 1'b0));
        rst_n         = 1'b1;
        bus.iEnSample = 1'b1;
        @(negedge clk);
        bus.iEnSample = 1'b0;
        chk("rst_idle_strobe", obs(), idle_exp(1'b0, 1'b0));
        bus.iCoeffUpdateFlag = 1'b1;
        @(negedge clk);
        chk("rst_to_load", obs(), idle_exp(1'b1, 1'b0));
        bus.iCoeffUpdateFlag = 1'b0;
        @(negedge clk);
        chk("rst_load_abort", obs(), idle_exp(1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coeff_update_ctrl.md
# coeff_update_ctrl

Sequencer directly upstream of the FIR module selector. It loads a stream of 40 filter coefficients into four single-port SRAM banks of 10 taps each, then runs one read/MAC sweep per input sample. All outputs drive the selector's bank-select, SRAM and MAC-enable inputs.

## Interface
Parameters:
- NUM_BANK, 4: number of SRAM/MAC banks; the select output width is log2(NUM_BANK).
- TAPS_PER_BANK, 10: coefficients per bank; must be ≤ 16.
- ADDR_W, 4: SRAM address width.
- DATA_W, 16: coefficient width.

Ports:
- iClk12M  in  1  system clock; all state changes on the rising edge.
- iRsn  in  1  asynchronous, active-low reset.
- iCoeffUpdateFlag  in  1  level; high requests or holds a coefficient load.
- iCoeffValid  in  1  coefficient word valid.
- iCoeffData  in  DATA_W  coefficient word.
- oCoeffReady  out  1  load handshake ready.
- iEnSample  in  1  one-cycle sample strobe.
- oModuleSel  out  2  bank select to the selector.
- oCsnRam  out  1  SRAM chip select, active-low.
- oWrnRam  out  1  SRAM write enable, active-low.
- oAddrRam  out  ADDR_W  SRAM address.
- oWtDtRam  out  DATA_W  SRAM write data.
- oEnMAC  out  1  MAC enable.
- oSweepDone  out  1  one-cycle pulse at the end of a sweep.
- oOverrun  out  1  sticky: a sample strobe was lost.

## Operation
- States: IDLE, LOAD, RUN_WAIT, SWEEP. Reset enters IDLE.
- Counters: bank (2 bit) and tap (0..TAPS_PER_BANK-1). The tap counter wraps to 0 and increments bank. Both counters clear on every entry to LOAD or SWEEP.
- IDLE:
  - iCoeffUpdateFlag=1 → LOAD.
  - Strobes are ignored and do not count as overrun.
- LOAD:
  - oCoeffReady=1 exactly while in LOAD.
  - A word is accepted when iCoeffValid & oCoeffReady at a clock edge.
  - Each accept issues one write: oModuleSel=bank, oAddrRam=tap, oWtDtRam=word, oCsnRam=0, oWrnRam=0.
  - After the 40th accept (bank=3, tap=9) → RUN_WAIT.
  - iCoeffUpdateFlag falls before the 40th accept → abort to IDLE. Partial writes remain in the SRAM.
  - Entry to LOAD clears oOverrun.
- RUN_WAIT:
  - iCoeffUpdateFlag=1 → LOAD. Update has priority over a same-cycle iEnSample, and that strobe is dropped without setting oOverrun.
  - Otherwise iEnSample=1 → SWEEP.
- SWEEP:
  - Runs 40 consecutive read cycles in bank-major, tap-minor order.
  - Each cycle drives oModuleSel=bank, oAddrRam=tap, oCsnRam=0, oWrnRam=1, oEnMAC=1, oWtDtRam=0.
  - After the last read → RUN_WAIT, with oSweepDone pulsed for one cycle.
  - iEnSample during SWEEP sets oOverrun; the sweep is not restarted.
  - iCoeffUpdateFlag during SWEEP is deferred until the sweep completes, then RUN_WAIT sees it → LOAD.
- Idle output values (any cycle with no write or read issued, and the reset value of every output):
  - oCsnRam=1, oWrnRam=1
  - oAddrRam=0, oWtDtRam=0, oModuleSel=0
  - oEnMAC=0, oSweepDone=0, oOverrun=0, oCoeffReady=0

## Timing
- All SRAM/MAC outputs are registered.
- A word accepted at edge N appears on the SRAM outputs in cycle N+1 for exactly one cycle.
- Back-to-back accepts produce back-to-back writes with no gap.
- LOAD with continuous valid takes 40 cycles. The first write appears one cycle after LOAD entry plus the first accept.
- oCoeffReady drops on the edge that takes the 40th accept.
- A strobe at edge N (in RUN_WAIT) puts the first read in cycle N+1. Reads 1..40 occupy cycles N+1..N+40.
- oSweepDone is high in cycle N+41, the first cycle in RUN_WAIT.
- Minimum sample spacing without overrun is 41 cycles.
- Asynchronous reset mid-operation forces IDLE and all idle output values immediately, with no further SRAM access.

## Structure
- Shared FIR package holds:
  - a state enum typedef;
  - NUM_BANK, TAPS_PER_BANK, ADDR_W, DATA_W and TOTAL_TAPS=NUM_BANK*TAPS_PER_BANK;
  - the idle values of the control outputs, to be used by the selector as well.
- One sub-module: tap_bank_counter, a tap/bank counter with clear, increment and last-flag outputs, shared by LOAD and SWEEP.
- FSM and output registers live in the top level.

## Test plan
- Reset behaviour: assert iRsn=0 mid-SWEEP at tap 5 → all outputs at idle values in the same cycle; state IDLE after release.
- Full load: flag=1, then 40 words 0x0100+k with continuous valid → writes at sel/addr (0,0)…(3,9) carrying data 0x0100…0x0127, no gaps; oCoeffReady low after the 40th word.
- Stalled load: valid toggles 1,0,1 → writes only in the cycle after each accept; no address skipped or repeated.
- Aborted load: flag drops after 17 words → IDLE, no further writes, oCoeffReady=0.
- Sweep: strobe in RUN_WAIT → 40 reads with oEnMAC=1, oWrnRam=1 in order (0,0)…(3,9); oSweepDone pulse at cycle +41.
- Overrun: strobe 20 cycles after sweep start → oOverrun=1 and sweep length unchanged; a later flag=1 reaches LOAD after sweep end and clears oOverrun.
